// File: rtl/insn_fetch_assembler.sv
// Instruction fetch stage: reads three consecutive 16-bit words from a synchronous
// instruction RAM and presents them as one 48-bit big-endian opcode over valid/ready.
module insn_fetch_assembler #(
  parameter int MEM_AW = 11,
  parameter int INSN_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [INSN_W-1:0] insn_data,
  output logic              insn_err
);

  if (INSN_W != 48) begin : g_bad_insn_w
    $error("insn_fetch_assembler: INSN_W must be 48 (three 16-bit words)");
  end
  if ((MEM_AW < 2) || (MEM_AW > 30)) begin : g_bad_mem_aw
    $error("insn_fetch_assembler: MEM_AW must be in 2..30");
  end

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_RD1  = 3'd2;
  localparam logic [2:0] S_RD2  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

  // Highest legal start word: the opcode needs w, w+1 and w+2 inside the RAM.
  localparam logic [MEM_AW-1:0] W_LAST = {{(MEM_AW-2){1'b1}}, 2'b01};
  localparam logic [MEM_AW-1:0] W_ONE  = {{(MEM_AW-1){1'b0}}, 1'b1};
  localparam logic [MEM_AW-1:0] W_TWO  = {{(MEM_AW-2){1'b0}}, 2'b10};

  logic [2:0]        state_q,      state_d;
  logic [MEM_AW-1:0] base_q,       base_d;
  logic [15:0]       word0_q,      word0_d;
  logic [15:0]       word1_q,      word1_d;
  logic              mem_rd_en_q,  mem_rd_en_d;
  logic [MEM_AW-1:0] mem_addr_q,   mem_addr_d;
  logic              insn_valid_q, insn_valid_d;
  logic [INSN_W-1:0] insn_data_q,  insn_data_d;
  logic              insn_err_q,   insn_err_d;

  logic [MEM_AW-1:0] req_w_s;
  logic              misaligned_s;
  logic              out_of_range_s;
  logic              req_err_s;
  logic              accept_s;

  assign req_w_s        = req_addr[MEM_AW:1];
  assign misaligned_s   = req_addr[0];
  assign out_of_range_s = (req_addr[31:MEM_AW+1] != '0) || (req_w_s > W_LAST);
  assign req_err_s      = misaligned_s || out_of_range_s;

  // A request offered alongside flush or reset must not be taken.
  assign req_ready = (state_q == S_IDLE) && !rst && !flush;
  assign accept_s  = req_valid && req_ready;

  // Next-state and output-register computation for the fetch sequencer.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    word0_d      = word0_q;
    word1_d      = word1_q;
    mem_rd_en_d  = mem_rd_en_q;
    mem_addr_d   = mem_addr_q;
    insn_valid_d = insn_valid_q;
    insn_data_d  = insn_data_q;
    insn_err_d   = insn_err_q;

    if (flush) begin
      state_d      = S_IDLE;
      word0_d      = 16'h0000;
      word1_d      = 16'h0000;
      mem_rd_en_d  = 1'b0;
      insn_valid_d = 1'b0;
      insn_err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            if (req_err_s) begin
              state_d      = S_HOLD;
              insn_valid_d = 1'b1;
              insn_err_d   = 1'b1;
              insn_data_d  = '0;
            end else begin
              state_d     = S_RD0;
              base_d      = req_w_s;
              mem_rd_en_d = 1'b1;
              mem_addr_d  = req_w_s;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RD0: begin
          state_d     = S_RD1;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = base_q + W_ONE;
        end
        S_RD1: begin
          state_d     = S_RD2;
          word0_d     = mem_rdata;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = base_q + W_TWO;
        end
        S_RD2: begin
          state_d     = S_WAIT;
          word1_d     = mem_rdata;
          mem_rd_en_d = 1'b0;
        end
        S_WAIT: begin
          // Third word arrives now; assemble directly from the RAM bus.
          state_d      = S_HOLD;
          insn_data_d  = {word0_q, word1_q, mem_rdata};
          insn_valid_d = 1'b1;
          insn_err_d   = 1'b0;
        end
        S_HOLD: begin
          if (insn_ready) begin
            state_d      = S_IDLE;
            insn_valid_d = 1'b0;
            insn_err_d   = 1'b0;
          end else begin
            state_d = S_HOLD;
          end
        end
        default: begin
          state_d      = S_IDLE;
          mem_rd_en_d  = 1'b0;
          insn_valid_d = 1'b0;
          insn_err_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      word0_q      <= 16'h0000;
      word1_q      <= 16'h0000;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      insn_valid_q <= 1'b0;
      insn_data_q  <= '0;
      insn_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      word0_q      <= word0_d;
      word1_q      <= word1_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_addr_q   <= mem_addr_d;
      insn_valid_q <= insn_valid_d;
      insn_data_q  <= insn_data_d;
      insn_err_q   <= insn_err_d;
    end
  end

  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign insn_valid = insn_valid_q;
  assign insn_data  = insn_data_q;
  assign insn_err   = insn_err_q;

endmodule
